// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle control FSM:
// state encodings, opcode constants and decode bundle.
package multicycle_ctrl_fsm_pkg;

    localparam int STATE_W     = 3;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [STATE_W-1:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // One-hot view of the opcode; all zero means illegal.
    typedef struct packed {
        logic r;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic addi;
    } op_dec_t;

    // True for states that own a memory request.
    function automatic logic is_mem_state(state_t s);
        return (s == S_IF) || (s == S_MEM);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_mem_wait_timer.sv
// Counts consecutive non-ready memory cycles and flags
// the last allowed wait cycle before a timeout trap.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(TIMEOUT - 1));

    // Saturating wait counter; clear has priority over counting.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (count_en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU control FSM: IF/ID/EX/MEM/WB sequencing with
// memory wait states, timeout/illegal-opcode trap and retire count.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int TIMEOUT  = TIMEOUT_DEF,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                stall,
    output logic [2:0]          state,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_write,
    output logic                pc_write,
    output logic                jump_take,
    output logic                branch_eval,
    output logic                reg_write,
    output logic                trap,
    output logic [CNT_W-1:0]    instr_count
);

    state_t  state_q;
    state_t  nxt;
    op_dec_t dec;
    logic    go;
    logic    retire;
    logic    expired;
    logic    wait_en;
    logic    wait_clr;

    assign dec.r    = (opcode == OPCODE_W'(OP_R));
    assign dec.lw   = (opcode == OPCODE_W'(OP_LW));
    assign dec.sw   = (opcode == OPCODE_W'(OP_SW));
    assign dec.beq  = (opcode == OPCODE_W'(OP_BEQ));
    assign dec.j    = (opcode == OPCODE_W'(OP_J));
    assign dec.addi = (opcode == OPCODE_W'(OP_ADDI));

    // Nothing advances or strobes under reset, stall or trap.
    assign go = !rst && !stall && (state_q != S_TRAP);

    assign state = state_q;
    assign trap  = (state_q == S_TRAP);

    // Waits count only while a request is actually presented.
    assign wait_en  = mem_req && !mem_ready;
    assign wait_clr = trap || (!stall && !wait_en);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .count_en (wait_en),
        .clear    (wait_clr),
        .expired  (expired)
    );

    // Next-state and strobe decode for the current state.
    always_comb begin
        nxt         = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        jump_take   = 1'b0;
        branch_eval = 1'b0;
        reg_write   = 1'b0;
        retire      = 1'b0;
        if (go) begin
            unique case (state_q)
                S_IF: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        nxt      = S_ID;
                    end else if (expired) begin
                        nxt = S_TRAP;
                    end
                end
                S_ID: begin
                    unique case (1'b1)
                        dec.j: begin
                            jump_take = 1'b1;
                            pc_write  = 1'b1;
                            retire    = 1'b1;
                            nxt       = S_IF;
                        end
                        dec.r, dec.lw, dec.sw,
                        dec.beq, dec.addi: nxt = S_EX;
                        default:           nxt = S_TRAP;
                    endcase
                end
                S_EX: begin
                    unique case (1'b1)
                        dec.beq: begin
                            branch_eval = 1'b1;
                            retire      = 1'b1;
                            nxt         = S_IF;
                        end
                        dec.lw, dec.sw:  nxt = S_MEM;
                        dec.r, dec.addi: nxt = S_WB;
                        default:         nxt = S_TRAP;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = dec.sw;
                    if (mem_ready) begin
                        unique case (1'b1)
                            dec.lw: nxt = S_WB;
                            dec.sw: begin
                                retire = 1'b1;
                                nxt    = S_IF;
                            end
                            default: nxt = S_TRAP;
                        endcase
                    end else if (expired) begin
                        nxt = S_TRAP;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    nxt       = S_IF;
                end
                default: nxt = S_TRAP;
            endcase
        end
    end

    // State register and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IF;
            instr_count <= '0;
        end else begin
            state_q <= nxt;
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: vector table,
// directed corner sequences and randomized model comparison.
module tb_multicycle_ctrl_fsm;
    import multicycle_ctrl_fsm_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       stall;

    always #5 clk = ~clk;

    logic [2:0]  a_state, b_state;
    logic        a_req, a_we, a_irw, a_pcw, a_jt, a_be, a_rw, a_trap;
    logic        b_req, b_we, b_irw, b_pcw, b_jt, b_be, b_rw, b_trap;
    logic [31:0] a_cnt;
    logic [1:0]  b_cnt;
    logic [10:0] a_out, b_out;

    assign a_out = {a_state, a_req, a_we, a_irw, a_pcw, a_jt, a_be, a_rw, a_trap};
    assign b_out = {b_state, b_req, b_we, b_irw, b_pcw, b_jt, b_be, b_rw, b_trap};

    multicycle_ctrl_fsm #(.OPCODE_W(6), .TIMEOUT(16), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .stall(stall), .state(a_state), .mem_req(a_req), .mem_we(a_we),
        .ir_write(a_irw), .pc_write(a_pcw), .jump_take(a_jt),
        .branch_eval(a_be), .reg_write(a_rw), .trap(a_trap),
        .instr_count(a_cnt)
    );

    multicycle_ctrl_fsm #(.OPCODE_W(6), .TIMEOUT(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .stall(stall), .state(b_state), .mem_req(b_req), .mem_we(b_we),
        .ir_write(b_irw), .pc_write(b_pcw), .jump_take(b_jt),
        .branch_eval(b_be), .reg_write(b_rw), .trap(b_trap),
        .instr_count(b_cnt)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [10:0] mk(input int st, input bit rq, input bit we,
                                       input bit irw, input bit pcw, input bit jt,
                                       input bit be, input bit rw, input bit tr);
        return {3'(st), rq, we, irw, pcw, jt, be, rw, tr};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input logic [5:0] o, input bit m, input bit s);
        rst = r; opcode = o; mem_ready = m; stall = s;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, OP_R, 1'b0, 1'b0);
        tick();
    endtask

    // Reference model: position within the opcode's route of phases.
    typedef struct {
        int pos;
        bit trapped;
        int waits;
        longint unsigned retired;
    } mdl_t;

    function automatic int rlen(input logic [5:0] o);
        case (o)
            OP_J:             return 2;
            OP_BEQ:           return 3;
            OP_R, OP_ADDI:    return 4;
            OP_SW:            return 4;
            OP_LW:            return 5;
            default:          return 0;
        endcase
    endfunction

    function automatic int phase(input logic [5:0] o, input int pos);
        if (pos == 3) return (o == OP_LW || o == OP_SW) ? 3 : 4;
        return pos;
    endfunction

    function automatic logic [10:0] mexp(input mdl_t m, input bit r, input logic [5:0] o,
                                         input bit rdy, input bit s);
        int ph;
        ph = phase(o, m.pos);
        if (m.trapped) return mk(5, 0, 0, 0, 0, 0, 0, 0, 1);
        if (r || s) return mk(ph, 0, 0, 0, 0, 0, 0, 0, 0);
        case (ph)
            0:       return mk(0, 1, 0, rdy, rdy, 0, 0, 0, 0);
            1:       return mk(1, 0, 0, 0, o == OP_J, o == OP_J, 0, 0, 0);
            2:       return mk(2, 0, 0, 0, 0, 0, o == OP_BEQ, 0, 0);
            3:       return mk(3, 1, o == OP_SW, 0, 0, 0, 0, 0, 0);
            default: return mk(4, 0, 0, 0, 0, 0, 0, 1, 0);
        endcase
    endfunction

    function automatic mdl_t mnext(input mdl_t m, input bit r, input logic [5:0] o,
                                   input bit rdy, input bit s, input int tmo);
        mdl_t n;
        int   ph;
        bit   adv;
        n = m;
        if (r) begin
            n.pos = 0; n.trapped = 0; n.waits = 0; n.retired = 0;
            return n;
        end
        if (m.trapped || s) return n;
        ph  = phase(o, m.pos);
        adv = 0;
        if (ph == 0 || ph == 3) begin
            if (rdy) begin
                adv = 1; n.waits = 0;
            end else begin
                n.waits++;
                if (n.waits == tmo) begin
                    n.trapped = 1; n.waits = 0;
                end
            end
        end else if (ph == 1 && rlen(o) == 0) begin
            n.trapped = 1;
        end else begin
            adv = 1;
        end
        if (adv) begin
            if (n.pos + 1 == rlen(o)) begin
                n.pos = 0; n.retired++;
            end else begin
                n.pos++;
            end
        end
        return n;
    endfunction

    typedef struct {
        bit          r;
        logic [5:0]  op;
        bit          rdy;
        bit          stl;
        logic [10:0] exp;
        int          cnt;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic [5:0] ill;
        int         we_seen;
        int         rw_seen;
        bit         rr, mm, ss;
        logic [5:0] oo;
        logic [5:0] legal[6];
        mdl_t       ma, mb;

        ill      = 6'b111111;
        legal[0] = OP_R;   legal[1] = OP_LW; legal[2] = OP_SW;
        legal[3] = OP_BEQ; legal[4] = OP_J;  legal[5] = OP_ADDI;

        tbl[0]  = '{1, OP_R,   1, 0, mk(0,0,0,0,0,0,0,0,0), 0};
        tbl[1]  = '{0, OP_R,   1, 0, mk(0,1,0,1,1,0,0,0,0), 0};
        tbl[2]  = '{0, OP_R,   1, 0, mk(1,0,0,0,0,0,0,0,0), 0};
        tbl[3]  = '{0, OP_R,   1, 0, mk(2,0,0,0,0,0,0,0,0), 0};
        tbl[4]  = '{0, OP_R,   1, 0, mk(4,0,0,0,0,0,0,1,0), 0};
        tbl[5]  = '{0, OP_SW,  1, 0, mk(0,1,0,1,1,0,0,0,0), 1};
        tbl[6]  = '{0, OP_SW,  1, 0, mk(1,0,0,0,0,0,0,0,0), 1};
        tbl[7]  = '{0, OP_SW,  1, 0, mk(2,0,0,0,0,0,0,0,0), 1};
        tbl[8]  = '{0, OP_SW,  1, 0, mk(3,1,1,0,0,0,0,0,0), 1};
        tbl[9]  = '{0, OP_J,   1, 0, mk(0,1,0,1,1,0,0,0,0), 2};
        tbl[10] = '{0, OP_J,   1, 0, mk(1,0,0,0,1,1,0,0,0), 2};
        tbl[11] = '{0, OP_R,   1, 0, mk(0,1,0,1,1,0,0,0,0), 3};
        tbl[12] = '{0, OP_BEQ, 1, 0, mk(1,0,0,0,0,0,0,0,0), 3};
        tbl[13] = '{0, OP_BEQ, 1, 1, mk(2,0,0,0,0,0,0,0,0), 3};
        tbl[14] = '{0, OP_BEQ, 1, 0, mk(2,0,0,0,0,0,1,0,0), 3};
        tbl[15] = '{0, OP_R,   0, 0, mk(0,1,0,0,0,0,0,0,0), 4};
        tbl[16] = '{0, OP_R,   1, 1, mk(0,0,0,0,0,0,0,0,0), 4};

        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].r, tbl[i].op, tbl[i].rdy, tbl[i].stl);
            chk($sformatf("tbl%0d_out", i), a_out, tbl[i].exp);
            chk($sformatf("tbl%0d_cnt", i), a_cnt, tbl[i].cnt);
            tick();
        end

        // lw with 2 IF waits and 3 MEM waits takes 10 cycles.
        do_reset();
        we_seen = 0; rw_seen = 0;
        for (int c = 0; c < 10; c++) begin
            drive(0, OP_LW, !(c < 2 || (c >= 5 && c <= 7)), 0);
            we_seen += a_we;
            rw_seen += a_rw;
            if (c == 8) chk("lw_mem_state", a_state, 3);
            tick();
        end
        drive(0, OP_LW, 0, 1);
        chk("lw_end_state", a_state, 0);
        chk("lw_cnt", a_cnt, 1);
        chk("lw_reg_write", rw_seen, 1);
        chk("lw_mem_we", we_seen, 0);
        tick();

        // Illegal opcode after one retired j: sticky trap, reset clears.
        do_reset();
        drive(0, OP_J, 1, 0); tick();
        drive(0, OP_J, 1, 0); tick();
        drive(0, ill, 1, 0); tick();
        drive(0, ill, 1, 0);
        chk("ill_id", a_state, 1);
        tick();
        for (int k = 0; k < 6; k++) begin
            drive(0, ill, k[0], k[1]);
            chk($sformatf("ill_trap%0d", k), a_out, mk(5,0,0,0,0,0,0,0,1));
            tick();
        end
        chk("ill_cnt_held", a_cnt, 1);
        drive(1, OP_R, 1, 0);
        chk("rst_strobes", a_out[7:1], 0);
        tick();
        drive(0, OP_R, 0, 0);
        chk("rst_release", a_out, mk(0,1,0,0,0,0,0,0,0));
        chk("rst_cnt", a_cnt, 0);
        tick();

        // TIMEOUT=4: four non-ready IF cycles trap, ready on the 4th does not.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(0, OP_R, 0, 0);
            if (k == 3) chk("to_last_wait", b_out, mk(0,1,0,0,0,0,0,0,0));
            tick();
        end
        drive(0, OP_R, 0, 0);
        chk("to_trap", b_out, mk(5,0,0,0,0,0,0,0,1));
        chk("to_no_trap_a", a_state, 0);
        tick();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(0, OP_R, k == 3, 0);
            tick();
        end
        drive(0, OP_R, 0, 1);
        chk("to_ready_wins", {b_state, b_trap}, {3'd1, 1'b0});
        tick();

        // Stall mid-MEM holds state and drops the request.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(0, OP_SW, 1, 0); tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, OP_SW, 1, 1);
            chk($sformatf("stall_mem%0d", k), {b_state, b_req}, {3'd3, 1'b0});
            tick();
        end
        drive(0, OP_SW, 1, 0);
        chk("stall_release", b_out, mk(3,1,1,0,0,0,0,0,0));
        tick();
        drive(0, OP_SW, 0, 1);
        chk("stall_sw_done", {b_state, b_cnt}, {3'd0, 2'd1});
        tick();

        // Waits split 2 + stall + 1 stay below TIMEOUT=4.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(0, OP_LW, 1, 0); tick();
        end
        drive(0, OP_LW, 0, 0); tick();
        drive(0, OP_LW, 0, 0); tick();
        drive(0, OP_LW, 0, 1); tick();
        drive(0, OP_LW, 0, 1); tick();
        drive(0, OP_LW, 0, 0); tick();
        drive(0, OP_LW, 1, 0);
        chk("split_wait_mem", b_out, mk(3,1,0,0,0,0,0,0,0));
        tick();
        drive(0, OP_LW, 0, 1);
        chk("split_wait_wb", b_state, 4);
        tick();

        // Counter wrap: five j on a 2-bit counter.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(0, OP_J, 1, 0); tick();
        end
        drive(0, OP_J, 0, 1);
        chk("wrap_cnt_b", b_cnt, 1);
        chk("wrap_cnt_a", a_cnt, 5);
        tick();

        // Randomized run against the phase-route model.
        do_reset();
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};
        oo = OP_R;
        for (int n = 0; n < 3000; n++) begin
            if (ma.trapped || mb.trapped) rr = ($urandom_range(0, 3) == 0);
            else                          rr = ($urandom_range(0, 99) == 0);
            if ((ma.trapped || ma.pos == 0) && (mb.trapped || mb.pos == 0)) begin
                if ($urandom_range(0, 15) < 14) oo = legal[$urandom_range(0, 5)];
                else                            oo = 6'($urandom);
            end
            mm = ($urandom_range(0, 9) < 6);
            ss = ($urandom_range(0, 9) < 2);
            drive(rr, oo, mm, ss);
            chk($sformatf("rnd%0d_a", n), {a_out, a_cnt},
                {mexp(ma, rr, oo, mm, ss), ma.retired[31:0]});
            chk($sformatf("rnd%0d_b", n), {b_out, b_cnt},
                {mexp(mb, rr, oo, mm, ss), mb.retired[1:0]});
            tick();
            ma = mnext(ma, rr, oo, mm, ss, 16);
            mb = mnext(mb, rr, oo, mm, ss, 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Parametrised successor to the multicycle CPU control state machine.
- Sequences each instruction through IF/ID/EX/MEM/WB and drives per-state strobes to PC, IR, register file and memory.
- New over the previous generation:
  - ready-handshaked memory access with wait states;
  - bounded-wait timeout into a TRAP state;
  - external stall;
  - illegal-opcode trap;
  - retired-instruction counter.
- Sits between the IR/opcode decode and the datapath; the ALU sign decode stays a separate block.

Parameters:
- OPCODE_W, 6, opcode field width.
- TIMEOUT, 16, maximum consecutive non-ready cycles allowed in IF or MEM before trapping (≥2).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  OPCODE_W  opcode from IR; valid from ID until instruction end.
- mem_ready  input  1  memory acknowledge for the current request.
- stall  input  1  freeze request.
- state  output  3  current state encoding.
- mem_req  output  1  memory request (IF fetch or MEM data).
- mem_we  output  1  data write qualifier (MEM state, sw).
- ir_write  output  1  IR load strobe.
- pc_write  output  1  PC update strobe.
- jump_take  output  1  PC source = jump target.
- branch_eval  output  1  beq compare/conditional PC update.
- reg_write  output  1  register file write strobe.
- trap  output  1  sticky error flag.
- instr_count  output  CNT_W  retired instructions, modulo 2^CNT_W.

Behaviour:
- Clocking and reset: one clock; synchronous active-high reset.
- Reset values: state=IF, wait counter=0, trap=0, instr_count=0, all strobes 0 while rst=1. After release, mem_req=1 in the first cycle.
- Registers: state, wait counter and instr_count are registered. Strobes are combinational from state, opcode, mem_ready and stall.
- State encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=5.
- Supported opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
- IF:
  - mem_req=1.
  - On mem_ready: ir_write=1, pc_write=1, go to ID.
- ID:
  - j: jump_take=1, pc_write=1, retire, go to IF.
  - R/lw/sw/beq/addi: go to EX.
  - Any other opcode: go to TRAP.
- EX:
  - beq: branch_eval=1, retire, go to IF.
  - lw/sw: go to MEM.
  - R/addi: go to WB.
- MEM:
  - mem_req=1, mem_we=(opcode==sw).
  - On mem_ready: lw goes to WB; sw retires and goes to IF.
- WB: reg_write=1, retire, go to IF.
- TRAP:
  - All strobes 0, trap=1.
  - Held until rst; stall and mem_ready are ignored.
- Retire: instr_count increments by 1 on the exiting edge; it wraps at 2^CNT_W.
- Minimum cycles per instruction: j=2, beq=3, R/addi=4, sw=4, lw=5.
- Wait counter:
  - Increments each cycle in IF/MEM with mem_req=1 and mem_ready=0.
  - Clears on mem_ready or on leaving the state.
  - If the counter equals TIMEOUT-1 and mem_ready=0, the next state is TRAP. The TIMEOUT-th non-ready cycle is the last one.
  - mem_ready on that same cycle wins: normal transition, no trap.
- stall=1 (outside TRAP):
  - State, wait counter and instr_count hold.
  - All strobes forced 0, including mem_req.
  - mem_ready is ignored while mem_req=0.
  - Stall cycles do not count toward the timeout.
- mem_ready outside IF/MEM is ignored.
- Reset mid-instruction: the outstanding memory request is abandoned, and the next cycle is IF with counters cleared.

Decomposition:
- Shared package/defines: state encodings and state width (3); opcode constants; TIMEOUT default.
- One sub-module, mem_wait_timer:
  - Inputs: clk, rst, count_en, clear.
  - Output: expired flag.
  - Counter width is $clog2(TIMEOUT).
- The FSM next-state and strobe logic stays in the top module.

Test Plan:
- R-type (000000) with mem_ready=1 always → states 0,1,2,4,0. reg_write is high exactly in cycle 4; instr_count goes 0→1.
- lw with mem_ready low 2 cycles in IF and 3 cycles in MEM → 10 cycles total. mem_we=0 throughout; reg_write once; instr_count=1.
- sw then j back-to-back with mem_ready=1 → sw has mem_we=1 only in MEM. j asserts jump_take and pc_write in ID and retires after 2 cycles; instr_count=2.
- Illegal opcode 111111 → TRAP after ID with trap=1 sticky. mem_req stays 0 despite mem_ready/stall toggling. rst restores IF with instr_count=0.
- TIMEOUT=4, mem_ready=0 in IF → TRAP on the edge after the 4th non-ready cycle. A variant with mem_ready on the 4th cycle must reach ID with trap=0.
- stall=1 for 3 cycles mid-MEM with mem_ready=1 → state holds at 3 and mem_req=0. With TIMEOUT=4, waits split 2+stall+1 do not trap. CNT_W=2: 5 retired instructions give instr_count=1.
